satatrn_txsched: RTL and testbench
==================================

# satatrn_txsched

Transport-layer transmit scheduler for host-to-device DMA data. Accepts a transfer length in dwords and splits the outgoing DMA word stream into DATA FIS payloads of at most `MAXFIS` dwords each. Before each FIS it waits for a DMA Activate from the device, and it drives the TX gate that lets the TX arbiter insert the DATA FIS header. It sits between the DMA read engine and the TX arbiter's data port, in the transport-layer clock domain.

## Interface
- `LGLEN`, 24: width of the transfer-length count, in dwords.
- `MAXFIS`, 2048: maximum payload dwords per DATA FIS; must be at least 1 and at most 2^LGLEN−1.
- `LGTIMEOUT`, 20: width of the DMA Activate timeout counter; used only with `SATATRN_TXSCHED_TIMEOUT_EN`.
- `i_clk`  in  1  clock; single clock domain.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  one-cycle pulse; begins a transfer; honoured only in IDLE.
- `i_len`  in  LGLEN  transfer length in dwords; sampled with `i_start`.
- `i_abort`  in  1  level or pulse; terminates the transfer.
- `i_dma_activate`  in  1  one-cycle pulse; a DMA Activate FIS was received.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle pulse on normal completion.
- `o_err`  out  1  one-cycle pulse on abort or timeout.
- `o_txgate`  out  1  permits the TX arbiter to open a DATA FIS.
- `i_valid`, `o_ready`, `i_data[31:0]`  in/out/in  DMA word stream (slave side).
- `o_valid`, `i_ready`, `o_data[31:0]`, `o_last`  out/in/out/out  stream to the TX arbiter data port (master side).

## Operation
- Registers:
  - `remaining` (LGLEN bits): dwords left in the whole transfer.
  - `fiscnt` (LGLEN bits): dwords left in the current FIS.
- States: IDLE, WAIT_ACT, XFER.
- IDLE:
  - `i_start` with `i_len` == 0: pulse `o_done` on the next cycle and stay in IDLE.
  - `i_start` with `i_len` ≠ 0: load `remaining` = `i_len` and go to WAIT_ACT.
- WAIT_ACT:
  - On `i_dma_activate`: load `fiscnt` = min(`remaining`, `MAXFIS`) and go to XFER.
  - `i_dma_activate` in any other state is ignored.
- XFER:
  - Datapath is a combinational pass-through: `o_valid` = `i_valid`, `o_ready` = `i_ready`, `o_data` = `i_data`.
  - Outside XFER, `o_valid` = 0 and `o_ready` = 0.
  - `o_last` = (`fiscnt` == 1) or abort pending.
  - On each accepted beat (`o_valid` && `i_ready`): decrement both `fiscnt` and `remaining`.
  - On the accepted beat that carries `o_last`:
    - If `remaining` becomes 0, pulse `o_done` and go to IDLE.
    - Otherwise go to WAIT_ACT.
- `o_txgate` is high from XFER entry until the FIS's first beat is accepted. It is low in every other case, so the arbiter opens exactly one FIS per DMA Activate.
- Abort:
  - In WAIT_ACT: go to IDLE and pulse `o_err` on the next cycle.
  - In XFER: set "abort pending". The next accepted beat carries `o_last` = 1 and closes the FIS cleanly. Then pulse `o_err` and go to IDLE.
  - Abort pending also clears if that accepted beat is already the last beat of the FIS.
  - In IDLE: ignored.
- Simultaneous events:
  - `i_start` while busy is ignored.
  - When abort and the natural final beat coincide, `o_err` wins and `o_done` is not pulsed.
  - `o_done` and `o_err` are never high together.

## Timing
- Reset values: state IDLE; `o_busy`, `o_done`, `o_err`, `o_txgate`, `o_valid`, `o_ready`, and `o_last` all 0; counters 0.
- Reset is honoured mid-transfer: the FIS in flight is abandoned and the outputs return to their reset values immediately.
- `i_start` to `o_busy` high: 1 cycle.
- `i_dma_activate` to `o_txgate` high and data flowing: 1 cycle.
- Stream latency: 0 cycles; no buffering.
- Final beat accepted to `o_done`/`o_err` high and `o_busy` low: 1 cycle; both pulses are registered.
- `o_valid` follows `i_valid` within XFER. Once a beat is presented, the producer must hold it until `i_ready`.

## Configuration
- `SATATRN_TXSCHED_TIMEOUT_EN`:
  - Defined: a `LGTIMEOUT`-bit counter runs in WAIT_ACT and restarts on each WAIT_ACT entry. When it reaches all-ones, the block pulses `o_err` and returns to IDLE.
  - Undefined: no counter; WAIT_ACT waits indefinitely, and only `i_abort` or `i_reset` can leave it.

## Test plan
- Single FIS: `i_len` = 5, one DMA Activate, `i_ready` = 1 → `o_txgate` high for 1 cycle; 5 beats with `o_last` on beat 5; `o_done` 1 cycle later.
- Split transfer: `MAXFIS` = 4, `i_len` = 10, three DMA Activates → FISes of 4, 4 and 2 beats with `o_last` on beats 4, 8 and 10; no beats accepted between the FISes until the next activate arrives.
- Zero length: `i_start` with `i_len` = 0 → `o_done` on the next cycle; `o_busy` never asserts.
- Mid-FIS abort: `i_len` = 8, abort after 3 beats → beat 4 carries `o_last`; `o_err` pulse; back to IDLE; beats 5–8 are never accepted.
- Backpressure: random `i_ready` and `i_valid` stalls during `i_len` = 6 → data order is preserved, exactly 6 beats, and `o_last` only on beat 6.
- Timeout (macro defined, `LGTIMEOUT` = 4): `i_start` with no activate → `o_err` after 15 cycles in WAIT_ACT. With the macro undefined, the block stays busy after 100 cycles.

Source files
------------

// File: rtl/satatrn_txsched.sv
// Transport-layer TX scheduler: splits a host-to-device DMA stream into DATA FIS payloads.
// Optional DMA Activate timeout is enabled with `define SATATRN_TXSCHED_TIMEOUT_EN.
module satatrn_txsched #(
    parameter int LGLEN     = 24,
    parameter int MAXFIS    = 2048,
    parameter int LGTIMEOUT = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LGLEN-1:0] i_len,
    input  logic             i_abort,
    input  logic             i_dma_activate,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_txgate,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_data,
    output logic             o_last
);

    localparam logic [LGLEN-1:0] MAXFIS_L = LGLEN'(MAXFIS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACT = 2'd1,
        XFER     = 2'd2
    } state_t;

    state_t           state;
    logic [LGLEN-1:0] remaining;
    logic [LGLEN-1:0] fiscnt;
    logic             abort_pend;
    logic             in_xfer;
    logic             aborting;
    logic             beat;

`ifdef SATATRN_TXSCHED_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] tcnt;
`else
    logic [LGTIMEOUT-1:0] unused_tmo;
    assign unused_tmo = '0;
`endif

    // Zero-latency pass-through; an abort raised this cycle already closes the FIS.
    assign in_xfer  = (state == XFER);
    assign aborting = abort_pend | i_abort;
    assign o_valid  = in_xfer & i_valid;
    assign o_ready  = in_xfer & i_ready;
    assign o_data   = in_xfer ? i_data : 32'd0;
    assign o_last   = in_xfer & ((fiscnt == {{(LGLEN-1){1'b0}}, 1'b1}) | aborting);
    assign beat     = o_valid & i_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            remaining  <= '0;
            fiscnt     <= '0;
            abort_pend <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_txgate   <= 1'b0;
`ifdef SATATRN_TXSCHED_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (i_start) begin
                        if (i_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            remaining <= i_len;
                            state     <= WAIT_ACT;
                            o_busy    <= 1'b1;
`ifdef SATATRN_TXSCHED_TIMEOUT_EN
                            tcnt      <= {{(LGTIMEOUT-1){1'b0}}, 1'b1};
`endif
                        end
                    end
                end
                WAIT_ACT: begin
`ifdef SATATRN_TXSCHED_TIMEOUT_EN
                    tcnt <= tcnt + 1'b1;
`endif
                    if (i_abort) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else if (i_dma_activate) begin
                        fiscnt   <= (remaining < MAXFIS_L) ? remaining : MAXFIS_L;
                        state    <= XFER;
                        o_txgate <= 1'b1;
                    end
`ifdef SATATRN_TXSCHED_TIMEOUT_EN
                    else if (tcnt == '1) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end
`endif
                end
                XFER: begin
                    if (i_abort)
                        abort_pend <= 1'b1;
                    if (beat) begin
                        fiscnt    <= fiscnt - 1'b1;
                        remaining <= remaining - 1'b1;
                        o_txgate  <= 1'b0;
                        if (o_last) begin
                            abort_pend <= 1'b0;
                            if (aborting) begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                                o_err  <= 1'b1;
                            end else if (remaining == {{(LGLEN-1){1'b0}}, 1'b1}) begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                            end else begin
                                state <= WAIT_ACT;
`ifdef SATATRN_TXSCHED_TIMEOUT_EN
                                tcnt  <= {{(LGTIMEOUT-1){1'b0}}, 1'b1};
`endif
                            end
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_satatrn_txsched.sv
// Randomized bench for satatrn_txsched with a transfer-level expectation model.
module tb_satatrn_txsched;

    localparam int LGLEN  = 16;
    localparam int MAXFIS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic [LGLEN-1:0] i_len = '0;
    logic             i_abort = 1'b0;
    logic             i_act = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_ready = 1'b0;
    logic [31:0]      i_data = '0;
    logic             o_busy, o_done, o_err, o_txgate, o_ready, o_valid, o_last;
    logic [31:0]      o_data;

    int    errors = 0;
    int    checks = 0;
    logic  acc;
    logic  hold = 1'b0;
    logic [31:0] base = '0;
    int    n = 0;

    always #5 clk = ~clk;

    satatrn_txsched #(.LGLEN(LGLEN), .MAXFIS(MAXFIS), .LGTIMEOUT(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_len(i_len),
        .i_abort(i_abort), .i_dma_activate(i_act),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_txgate(o_txgate),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive after the falling edge, sample what the next rising edge will act on.
    task automatic cyc(input logic st, input logic [LGLEN-1:0] ln, input logic ab,
                       input logic act, input logic v, input logic r);
        @(negedge clk);
        i_start = st;
        i_len   = ln;
        i_abort = ab;
        i_act   = act;
        i_valid = v;
        i_ready = r;
        i_data  = base + 32'(n);
        #1;
        acc  = o_valid & i_ready;
        hold = v & ~acc;
    endtask

    function automatic logic rbit(input logic rnd);
        return rnd ? logic'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // abort_after < 0 means no abort; otherwise abort is held once that many beats went out.
    task automatic run_xfer(input int len, input int abort_after, input logic rnd);
        int fl, k, budget, gap;
        logic aborted, ab, v;
        base = $urandom;
        n = 0;
        aborted = 1'b0;
        cyc(1'b1, LGLEN'(len), 1'b0, 1'b0, 1'b0, 1'b0);
        check("busy_pre", 32'(o_busy), 0);
        while (n < len && !aborted) begin
            gap = rnd ? $urandom_range(0, 3) : 0;
            for (int g = 0; g < gap; g++) begin
                v = hold | rbit(rnd);
                cyc(logic'($urandom_range(0, 1)), LGLEN'($urandom_range(1, 20)), 1'b0, 1'b0, v, rbit(rnd));
                check("gap_noacc", 32'(acc), 0);
                check("gap_gate", 32'(o_txgate), 0);
                check("gap_busy", 32'(o_busy), 1);
            end
            v = hold | rbit(rnd);
            cyc(1'b0, '0, 1'b0, 1'b1, v, rbit(rnd));
            check("act_noacc", 32'(acc), 0);
            fl = (len - n < MAXFIS) ? len - n : MAXFIS;
            k = 0;
            budget = 0;
            while (k < fl && !aborted && budget < 200) begin
                ab = (abort_after >= 0) && (n >= abort_after);
                v = hold | rbit(rnd);
                cyc(1'b0, '0, ab, rnd ? ($urandom_range(0, 3) == 0) : 1'b0, v, rbit(rnd));
                budget++;
                check("gate", 32'(o_txgate), 32'(k == 0));
                check("busy", 32'(o_busy), 1);
                if (acc) begin
                    check("data", o_data, base + 32'(n));
                    check("last", 32'(o_last), 32'((k == fl - 1) || ab));
                    n++;
                    k++;
                    if (ab) aborted = 1'b1;
                end
            end
            if (budget >= 200) begin
                check("beat_budget", 0, 1);
                aborted = 1'b1;
            end
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("done", 32'(o_done), 32'(!aborted));
        check("err", 32'(o_err), 32'(aborted));
        check("busy_post", 32'(o_busy), 0);
        if (abort_after >= 0 && abort_after < len)
            check("beats_on_abort", n, abort_after + 1);
        else
            check("beats_total", n, len);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("done_clr", 32'(o_done), 0);
        check("err_clr", 32'(o_err), 0);
    endtask

    initial begin
        int cnt;
        i_valid = 1'b1;
        i_ready = 1'b1;
        #12;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_gate", 32'(o_txgate), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_ready", 32'(o_ready), 0);
        check("rst_last", 32'(o_last), 0);
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;

        // zero length
        cyc(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("zl_done", 32'(o_done), 1);
        check("zl_busy", 32'(o_busy), 0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("zl_done_clr", 32'(o_done), 0);
        check("zl_busy2", 32'(o_busy), 0);

        run_xfer(3, -1, 1'b0);
        run_xfer(10, -1, 1'b0);
        run_xfer(8, 3, 1'b0);
        run_xfer(6, -1, 1'b1);
        run_xfer(8, 4, 1'b1);
        run_xfer(4, 3, 1'b0);
        for (int t = 0; t < 12; t++)
            run_xfer($urandom_range(1, 13), ($urandom_range(0, 2) == 0) ? $urandom_range(0, 12) : -1, 1'b1);

        // abort while waiting for activate
        cyc(1'b1, LGLEN'(8), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wa_busy", 32'(o_busy), 1);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("wa_err", 32'(o_err), 1);
        check("wa_busy_post", 32'(o_busy), 0);
        check("wa_noacc", 32'(acc), 0);

        // reset mid-FIS
        n = 0;
        cyc(1'b1, LGLEN'(6), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mr_acc", 32'(acc), 1);
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(o_valid), 0);
        check("mr_ready", 32'(o_ready), 0);
        check("mr_last", 32'(o_last), 0);
        check("mr_gate", 32'(o_txgate), 0);
        check("mr_busy", 32'(o_busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // no activate: timeout or indefinite wait
        cyc(1'b1, LGLEN'(5), 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SATATRN_TXSCHED_TIMEOUT_EN
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (o_err) break;
            if (o_busy) cnt++;
        end
        check("tmo_err", 32'(o_err), 1);
        check("tmo_cycles", cnt, 15);
`else
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (o_busy && !o_err) cnt++;
        end
        check("wait_busy", cnt, 100);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wait_abort_err", 32'(o_err), 1);
`endif
        check("end_busy", 32'(o_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
